// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared state encodings and per-stage control vectors for the pipeline stall controller.
package pipeline_stall_ctrl_pkg;

    localparam int PSC_STATE_W = 2;

    typedef enum logic [PSC_STATE_W-1:0] {
        PSC_RUN   = 2'd0,
        PSC_IMISS = 2'd1,
        PSC_DMISS = 2'd2,
        PSC_BOTH  = 2'd3
    } psc_state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_flush;
        logic ex_mem_write;
        logic mem_wb_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_NORMAL   = pipe_ctrl_t'(7'b1101010);
    localparam pipe_ctrl_t CTRL_FREEZE   = pipe_ctrl_t'(7'b0000001);
    localparam pipe_ctrl_t CTRL_LOAD_USE = pipe_ctrl_t'(7'b0001110);
    localparam pipe_ctrl_t CTRL_IHOLD    = pipe_ctrl_t'(7'b0111010);
    localparam pipe_ctrl_t CTRL_REDIRECT = pipe_ctrl_t'(7'b1111110);
    localparam pipe_ctrl_t CTRL_RESET    = pipe_ctrl_t'(7'b0010101);

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard/cache handshake inputs and pipeline-register controls of the stall controller.
// PIPE_PERF_CNT_EN adds the three performance counters.
interface pipeline_stall_ctrl_if;
    import pipeline_stall_ctrl_pkg::*;

    logic load_use_stall;
    logic ex_redirect;
    logic icache_miss;
    logic icache_ready;
    logic dcache_miss;
    logic dcache_ready;

    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_write;
    logic mem_wb_flush;
    logic stall_timeout;
    logic [PSC_STATE_W-1:0] ctrl_state;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_lu_bubbles;
    logic [31:0] perf_imiss_cycles;
    logic [31:0] perf_dmiss_cycles;
`endif

    modport master (
        output load_use_stall, ex_redirect, icache_miss, icache_ready, dcache_miss, dcache_ready,
        input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write,
               mem_wb_flush, stall_timeout, ctrl_state
`ifdef PIPE_PERF_CNT_EN
        , input perf_lu_bubbles, perf_imiss_cycles, perf_dmiss_cycles
`endif
    );

    modport slave (
        input  load_use_stall, ex_redirect, icache_miss, icache_ready, dcache_miss, dcache_ready,
        output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write,
               mem_wb_flush, stall_timeout, ctrl_state
`ifdef PIPE_PERF_CNT_EN
        , output perf_lu_bubbles, perf_imiss_cycles, perf_dmiss_cycles
`endif
    );

endinterface

// File: rtl/pipeline_stall_ctrl_stall_watchdog.sv
// Saturating stall-cycle counter with a sticky timeout flag once MAX_STALL is reached.
module stall_watchdog #(
    parameter int MAX_STALL = 255,
    parameter int CNT_W     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic stall,
    output logic stall_timeout
);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(MAX_STALL);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = '0;
        if (stall)
            cnt_nxt = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= '0;
            stall_timeout <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (cnt_nxt == LIMIT)
                stall_timeout <= 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Merges load-use, redirect and cache-miss requests into per-stage write/flush controls.
// PIPE_PERF_CNT_EN adds load-use / I-miss / D-miss cycle counters.
//
// state | meaning
// RUN   | pipeline flowing; RUN priority: dcache_miss, ex_redirect, load_use, icache_miss
// IMISS | fetch waiting on I-cache refill; back end advances
// DMISS | whole pipeline frozen on D-cache refill
// BOTH  | both refills outstanding; whole pipeline frozen
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int MAX_STALL = 255,
    parameter int CNT_W     = 8
) (
    input  logic clk,
    input  logic rst,
    pipeline_stall_ctrl_if.slave bus
);
    psc_state_e state, state_nxt;
    logic       kill, kill_nxt;
    pipe_ctrl_t ctl;
    logic       timeout;

    // kill marks an outstanding fetch as wrong-path; its data is flushed and PC left on the target.
    always_comb begin
        state_nxt = state;
        kill_nxt  = kill;
        ctl       = CTRL_NORMAL;
        unique case (state)
            PSC_RUN: begin
                if (bus.dcache_miss) begin
                    ctl       = CTRL_FREEZE;
                    state_nxt = bus.icache_miss ? PSC_BOTH : PSC_DMISS;
                end else if (bus.ex_redirect) begin
                    ctl = CTRL_REDIRECT;
                    if (bus.icache_miss) begin
                        state_nxt = PSC_IMISS;
                        kill_nxt  = 1'b1;
                    end
                end else if (bus.load_use_stall) begin
                    ctl = CTRL_LOAD_USE;
                end else if (bus.icache_miss) begin
                    ctl       = CTRL_IHOLD;
                    state_nxt = PSC_IMISS;
                end
            end
            PSC_IMISS: begin
                if (bus.dcache_miss) begin
                    ctl       = CTRL_FREEZE;
                    state_nxt = bus.icache_ready ? PSC_DMISS : PSC_BOTH;
                end else if (bus.ex_redirect) begin
                    ctl = CTRL_REDIRECT;
                    if (bus.icache_ready) begin
                        state_nxt = PSC_RUN;
                        kill_nxt  = 1'b0;
                    end else begin
                        kill_nxt  = 1'b1;
                    end
                end else if (bus.icache_ready) begin
                    ctl       = kill ? CTRL_IHOLD : CTRL_NORMAL;
                    state_nxt = PSC_RUN;
                    kill_nxt  = 1'b0;
                end else begin
                    ctl = CTRL_IHOLD;
                end
            end
            PSC_DMISS: begin
                ctl = CTRL_FREEZE;
                if (bus.dcache_ready) begin
                    ctl       = kill ? CTRL_IHOLD : CTRL_NORMAL;
                    state_nxt = PSC_RUN;
                    kill_nxt  = 1'b0;
                end
            end
            PSC_BOTH: begin
                ctl = CTRL_FREEZE;
                if (bus.icache_ready && bus.dcache_ready) begin
                    ctl       = kill ? CTRL_IHOLD : CTRL_NORMAL;
                    state_nxt = PSC_RUN;
                    kill_nxt  = 1'b0;
                end else if (bus.dcache_ready) begin
                    ctl       = CTRL_IHOLD;
                    state_nxt = PSC_IMISS;
                end else if (bus.icache_ready) begin
                    state_nxt = PSC_DMISS;
                end
            end
        endcase
        if (rst)
            ctl = CTRL_RESET;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= PSC_RUN;
            kill  <= 1'b0;
        end else begin
            state <= state_nxt;
            kill  <= kill_nxt;
        end
    end

    stall_watchdog #(
        .MAX_STALL (MAX_STALL),
        .CNT_W     (CNT_W)
    ) u_watchdog (
        .clk           (clk),
        .rst           (rst),
        .stall         ((state != PSC_RUN) || bus.load_use_stall),
        .stall_timeout (timeout)
    );

    assign bus.pc_write      = ctl.pc_write;
    assign bus.if_id_write   = ctl.if_id_write;
    assign bus.if_id_flush   = ctl.if_id_flush;
    assign bus.id_ex_write   = ctl.id_ex_write;
    assign bus.id_ex_flush   = ctl.id_ex_flush;
    assign bus.ex_mem_write  = ctl.ex_mem_write;
    assign bus.mem_wb_flush  = ctl.mem_wb_flush;
    assign bus.stall_timeout = timeout;
    assign bus.ctrl_state    = state;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] lu_cnt, imiss_cnt, dmiss_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lu_cnt    <= '0;
            imiss_cnt <= '0;
            dmiss_cnt <= '0;
        end else begin
            if (state == PSC_RUN && bus.load_use_stall && !bus.dcache_miss && !bus.ex_redirect)
                lu_cnt <= lu_cnt + 32'd1;
            if (state == PSC_IMISS || state == PSC_BOTH)
                imiss_cnt <= imiss_cnt + 32'd1;
            if (state == PSC_DMISS || state == PSC_BOTH)
                dmiss_cnt <= dmiss_cnt + 32'd1;
        end
    end

    assign bus.perf_lu_bubbles   = lu_cnt;
    assign bus.perf_imiss_cycles = imiss_cnt;
    assign bus.perf_dmiss_cycles = dmiss_cnt;
`endif

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Central sequencer for the pipeline-register enables and flushes. It merges four inputs into one per-stage control vector each cycle:
- the decode-stage load-use stall from the hazard unit
- EX-stage redirects (branch mispredict or exception)
- I-cache miss handshake
- D-cache miss handshake

It sits beside the hazard detector in the core top level and drives PC, IF/ID, ID/EX, EX/MEM and MEM/WB write and flush controls. A stall watchdog flags pipelines frozen for too long.

Parameters:
- MAX_STALL, 255: stall cycles tolerated before stall_timeout asserts.
- CNT_W, 8: watchdog counter width; must satisfy 2^CNT_W > MAX_STALL.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- load_use_stall  in  1  hazard-unit load-use stall (decode stage)
- ex_redirect  in  1  EX-stage branch mispredict or exception; PC must load target
- icache_miss  in  1  fetch missed; level, held until icache_ready
- icache_ready  in  1  refill done; one-cycle pulse
- dcache_miss  in  1  MEM-stage access missed; level, held until dcache_ready
- dcache_ready  in  1  refill done; one-cycle pulse
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID enable
- if_id_flush  out  1  IF/ID becomes bubble
- id_ex_write  out  1  ID/EX enable
- id_ex_flush  out  1  ID/EX becomes bubble
- ex_mem_write  out  1  EX/MEM enable
- mem_wb_flush  out  1  MEM/WB becomes bubble
- stall_timeout  out  1  sticky watchdog flag
- ctrl_state  out  2  current FSM state (debug)

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- FSM states (ctrl_state encoding): RUN=0, IMISS=1, DMISS=2, BOTH=3.
- Control outputs are combinational from state plus inputs. FSM, kill flag and watchdog are registered.
- Reset values:
  - State RUN, kill flag 0, watchdog 0, stall_timeout 0.
  - Outputs while rst=1: all *_write=0, all *_flush=1.
- Priority in RUN, oldest stage first:
  1. dcache_miss: freeze all stages. pc_write, if_id_write, id_ex_write, ex_mem_write all 0; mem_wb_flush=1. Next state DMISS, or BOTH if icache_miss is also high.
  2. ex_redirect: pc_write=1, if_id_flush=1, id_ex_flush=1, all writes 1. Any icache_miss this cycle is for a wrong-path fetch: next state IMISS with kill=1.
  3. load_use_stall: pc_write=0, if_id_write=0, id_ex_flush=1, downstream advances. Bubble lasts exactly one cycle per assertion.
  4. icache_miss: pc_write=0, if_id_flush=1, downstream advances. Next state IMISS.
  5. None of the above: all writes 1, all flushes 0.
- IMISS:
  - Front end held as in rule 4; back end advances.
  - ex_redirect: pc_write=1, flushes as in rule 2, set kill.
  - dcache_miss: freeze back end as in rule 1; next state BOTH.
  - icache_ready: next state RUN, clear kill. If kill was set, if_id_flush=1 that cycle (discard the wrong-path instruction). Otherwise normal write.
- DMISS:
  - Full freeze as in rule 1.
  - dcache_ready: that cycle all writes=1, mem_wb_flush=0; next state RUN.
  - ex_redirect and load_use_stall are ignored; they re-evaluate after the freeze.
- BOTH:
  - Full freeze.
  - dcache_ready first: go to IMISS.
  - icache_ready first: go to DMISS; the fetched instruction latches into IF/ID once the freeze lifts.
  - Both ready in the same cycle: go to RUN.
- Watchdog:
  - Counts every cycle with state≠RUN or load_use_stall=1. Clears on any cycle in RUN with no stall.
  - Saturates at 2^CNT_W−1.
  - When the count reaches MAX_STALL, stall_timeout sets and stays set until rst.
- Reset mid-miss: returns to RUN immediately. The caches must drop their miss lines on the same reset.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- When defined:
  - Adds three 32-bit wrapping output counters: perf_lu_bubbles (load-use cycles), perf_imiss_cycles (state IMISS or BOTH), perf_dmiss_cycles (state DMISS or BOTH).
  - Counters reset to 0.
- When undefined: these ports and their logic are absent. All other behaviour is identical.

Decomposition:
- define.v additions: state encodings `PSC_RUN, `PSC_IMISS, `PSC_DMISS, `PSC_BOTH; `PSC_STATE_W=2.
- One sub-module, stall_watchdog: counter, saturation and sticky flag, parameterised by MAX_STALL and CNT_W.
- FSM and output decode stay in pipeline_stall_ctrl.

Test Plan:
- Load-use: load_use_stall=1 for one cycle in RUN → pc_write=0, if_id_write=0, id_ex_flush=1 for exactly that cycle; next cycle all writes=1.
- D-miss: dcache_miss high 5 cycles, dcache_ready on cycle 5 → state DMISS cycles 2–5, ex_mem_write=0 and mem_wb_flush=1 on cycles 1–4, all writes=1 on cycle 5, RUN on cycle 6.
- Redirect during I-miss: icache_miss, then ex_redirect 2 cycles later, icache_ready 3 cycles after that → pc_write=1 on redirect cycle, if_id_flush=1 on ready cycle, state RUN afterwards.
- Overlap: icache_miss and dcache_miss together, dcache_ready at cycle 3, icache_ready at cycle 6 → states BOTH, BOTH, IMISS, …, RUN; back end frozen only until cycle 3.
- Watchdog: MAX_STALL=4, dcache_miss held 10 cycles → stall_timeout rises when the count reaches 4 and stays 1 after dcache_ready, until rst.
- Async reset: assert rst mid-DMISS, asynchronous to clk → ctrl_state=0 and flushes=1 immediately without a clock edge; normal RUN after release.
